// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute.
// Decodes the opcode into a one-hot format type and extracts the register
// and function fields. A two-entry skid buffer, made of the output register
// and one skid register, gives full throughput. o_in_ready is itself a
// register, so there is no combinational path from i_ready to o_in_ready.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN. When it is defined,
// o_illegal flags unrecognised opcodes. When it is not defined, o_illegal
// is tied low.
module decode_stage #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter bit          ZERO_UNUSED = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_in_ready,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_inst,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [5:0]          o_type,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [2:0]          o_funct3,
  output logic [6:0]          o_funct7,
  output logic                o_illegal
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned TYPE_W = 6;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [PC_WIDTH-1:0] pc;
    logic [TYPE_W-1:0]   fmt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                illegal;
  } payload_t;

  payload_t dec;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept;
  logic     transfer;

  assign accept   = i_valid & in_ready_q;
  assign transfer = out_valid_q & i_ready;

  // Combinational decode of the incoming word
  always_comb begin
    dec        = '0;
    dec.inst   = i_inst;
    dec.pc     = i_pc;
    dec.rd     = i_inst[11:7];
    dec.rs1    = i_inst[19:15];
    dec.rs2    = i_inst[24:20];
    dec.funct3 = i_inst[14:12];
    dec.funct7 = i_inst[31:25];
    case (i_inst[6:0])
      7'b0110011:                       dec.fmt = 6'b000001;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:           dec.fmt = 6'b000010;
      7'b0100011:                       dec.fmt = 6'b000100;
      7'b1100011:                       dec.fmt = 6'b001000;
      7'b0110111, 7'b0010111:           dec.fmt = 6'b010000;
      7'b1101111:                       dec.fmt = 6'b100000;
      default:                          dec.fmt = 6'b000000;
    endcase
    if (ZERO_UNUSED) begin
      if (dec.fmt[4] | dec.fmt[5])              dec.rs1 = '0;
      if (dec.fmt[1] | dec.fmt[4] | dec.fmt[5]) dec.rs2 = '0;
      if (dec.fmt[2] | dec.fmt[3])              dec.rd  = '0;
    end
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (dec.fmt == '0);
`else
    dec.illegal = 1'b0;
`endif
  end

  // Skid-buffer next state; a flush drops everything, including this cycle's input
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || transfer) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign o_in_ready = in_ready_q;
  assign o_valid    = out_valid_q;
  assign o_inst     = out_q.inst;
  assign o_pc       = out_q.pc;
  assign o_type     = out_q.fmt;
  assign o_rd       = out_q.rd;
  assign o_rs1      = out_q.rs1;
  assign o_rs2      = out_q.rs2;
  assign o_funct3   = out_q.funct3;
  assign o_funct7   = out_q.funct7;
  assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [5:0]  out_type;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.PC_WIDTH(32), .ZERO_UNUSED(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_in_ready(in_ready),
    .i_inst(in_inst), .i_pc(in_pc), .i_flush(flush), .o_valid(out_valid),
    .i_ready(out_ready), .o_inst(out_inst), .o_pc(out_pc), .o_type(out_type),
    .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2), .o_funct3(funct3), .o_funct7(funct7),
    .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_type", 64'(out_type), 64'd0);
    chk("rst_fields", 64'({rd, rs1, rs2, funct3, funct7, illegal}), 64'd0);
    rst = 1'b0;

    // addi x1,x2,5
    drive(1'b1, 32'h00510093, 32'h100); tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_type", 64'(out_type), 64'b000010);
    chk("addi_rd", 64'(rd), 64'd1);
    chk("addi_rs1", 64'(rs1), 64'd2);
    chk("addi_rs2", 64'(rs2), 64'd0);
    chk("addi_f3", 64'(funct3), 64'd0);
    chk("addi_pc", 64'(out_pc), 64'h100);
    chk("addi_inst", 64'(out_inst), 64'h00510093);

    // sw x5,8(x2)
    drive(1'b1, 32'h00512423, 32'h104); tick();
    chk("sw_type", 64'(out_type), 64'b000100);
    chk("sw_regs", 64'({rd, rs1, rs2}), 64'({5'd0, 5'd2, 5'd5}));
    chk("sw_f3", 64'(funct3), 64'd2);

    // lui x3,0x12345
    drive(1'b1, 32'h123451B7, 32'h108); tick();
    chk("lui_type", 64'(out_type), 64'b010000);
    chk("lui_regs", 64'({rd, rs1, rs2}), 64'({5'd3, 5'd0, 5'd0}));

    // jal x0,0
    drive(1'b1, 32'h0000006F, 32'h10C); tick();
    chk("jal_type", 64'(out_type), 64'b100000);

    // sub x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'h110); tick();
    chk("sub_type", 64'(out_type), 64'b000001);
    chk("sub_regs", 64'({rd, rs1, rs2}), 64'({5'd3, 5'd1, 5'd2}));
    chk("sub_f7", 64'(funct7), 64'h20);

    // beq x1,x2,8 : raw rd field 8 is zeroed
    drive(1'b1, 32'h00208463, 32'h114); tick();
    chk("beq_type", 64'(out_type), 64'b001000);
    chk("beq_regs", 64'({rd, rs1, rs2}), 64'({5'd0, 5'd1, 5'd2}));

    // all-zero word is unrecognised
    drive(1'b1, 32'h00000000, 32'h118); tick();
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_type", 64'(out_type), 64'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("zero_illegal", 64'(illegal), 64'd1);
`else
    chk("zero_illegal", 64'(illegal), 64'd0);
`endif

    // back-to-back stream of 8 addi words, rd = k
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'h00000013 | (32'(k) << 7), 32'h200 + 32'(4 * k)); tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_rd", 64'(rd), 64'(k));
      chk("stream_pc", 64'(out_pc), 64'h200 + 64'(4 * k));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, '0); tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // stall: two words arrive while downstream is not ready
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00513, 32'h300); tick();
    chk("stall_a_valid", 64'(out_valid), 64'd1);
    chk("stall_a_pc", 64'(out_pc), 64'h300);
    chk("stall_a_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h01400593, 32'h304); tick();
    chk("stall_hold_pc", 64'(out_pc), 64'h300);
    chk("stall_hold_inst", 64'(out_inst), 64'h00A00513);
    chk("stall_full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, '0, '0); tick();
    chk("stall_still_pc", 64'(out_pc), 64'h300);
    chk("stall_still_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; tick();
    chk("drain_b_valid", 64'(out_valid), 64'd1);
    chk("drain_b_pc", 64'(out_pc), 64'h304);
    chk("drain_b_rd", 64'(rd), 64'd11);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // flush with output and skid full, while a third word is offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00100613, 32'h400); tick();
    drive(1'b1, 32'h00200693, 32'h404); tick();
    chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00300713, 32'h408); tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0); tick();
    chk("post_flush_valid", 64'(out_valid), 64'd0);
    tick();
    chk("post_flush_valid2", 64'(out_valid), 64'd0);

    // reset mid-stream with a full buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h00100613, 32'h500); tick();
    drive(1'b1, 32'h00200693, 32'h504); tick();
    rst = 1'b1; drive(1'b0, '0, '0); tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_inst", 64'(out_inst), 64'd0);
    rst = 1'b0; out_ready = 1'b1; tick();
    chk("mid_rst_no_skid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
